// File: rtl/demux1an_rr_param.sv
// 1-to-N demultiplexer with round-robin or directed channel selection.
// Each output channel is registered and accepts a word only when its own ready is high.

module demux1an_ch #(
  parameter int DATA_W = 4,
  parameter int HOLD   = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);
  logic              valid_q;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (load_i)         data_d = data_i;
    else if (HOLD == 0) data_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= load_i;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule

module demux1an_rr_param #(
  parameter  int DATA_W = 4,
  parameter  int N_CH   = 4,
  parameter  int HOLD   = 1,
  localparam int SEL_W  = $clog2(N_CH)
) (
  input  logic                   clk_2f,
  input  logic                   reset,
  input  logic                   valid_in,
  input  logic [DATA_W-1:0]      data_in,
  output logic                   ready_in,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       sel_in,
  input  logic [N_CH-1:0]        ready_out,
  output logic [N_CH-1:0]        valid_out,
  output logic [N_CH*DATA_W-1:0] data_out,
  output logic [SEL_W-1:0]       rr_ptr,
  output logic                   sel_err
);
  logic [SEL_W-1:0] tgt, rr_ptr_q, rr_ptr_d;
  logic [N_CH-1:0]  hit, load;
  logic             accept, sel_oor, sel_err_q;

  assign tgt = mode ? sel_in : rr_ptr_q;

  // hit is all-zero for an out-of-range target, which also blocks ready_in.
  for (genvar k = 0; k < N_CH; k++) begin : g_hit
    assign hit[k] = (tgt == SEL_W'(k));
  end

  assign ready_in = !reset & |(hit & ready_out);
  assign accept   = valid_in & ready_in;
  assign load     = accept ? hit : '0;
  assign sel_oor  = mode & ({1'b0, sel_in} >= (SEL_W+1)'(N_CH));

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept && !mode)
      rr_ptr_d = (rr_ptr_q == SEL_W'(N_CH-1)) ? '0 : rr_ptr_q + SEL_W'(1);
  end

  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      rr_ptr_q  <= '0;
      sel_err_q <= 1'b0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      sel_err_q <= valid_in & sel_oor;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    demux1an_ch #(.DATA_W(DATA_W), .HOLD(HOLD)) u_ch (
      .clk_i  (clk_2f),
      .rst_i  (reset),
      .load_i (load[k]),
      .data_i (data_in),
      .valid_o(valid_out[k]),
      .data_o (data_out[k*DATA_W +: DATA_W])
    );
  end

  assign rr_ptr  = rr_ptr_q;
  assign sel_err = sel_err_q;
endmodule

// File: tb/tb_demux1an_rr_param.sv
// Bench for demux1an_rr_param: vector table with a scoreboard on a 4-channel HOLD=1
// instance, plus hand sequences for range errors, HOLD=0, wrap at 3 and async reset.

module tb_demux1an_rr_param;
  logic clk_2f = 1'b0;
  logic reset;
  always #5 clk_2f = ~clk_2f;

  // 4-channel, HOLD=1
  logic        valid_in, ready_in, mode, sel_err;
  logic [3:0]  data_in, ready_out, valid_out;
  logic [1:0]  sel_in, rr_ptr;
  logic [15:0] data_out;

  // 3-channel, HOLD=0
  logic        v3, rin3, m3, serr3;
  logic [3:0]  d3;
  logic [1:0]  s3, ptr3;
  logic [2:0]  r3, vout3;
  logic [11:0] dout3;

  demux1an_rr_param #(.DATA_W(4), .N_CH(4), .HOLD(1)) u_dut (
    .clk_2f(clk_2f), .reset(reset), .valid_in(valid_in), .data_in(data_in),
    .ready_in(ready_in), .mode(mode), .sel_in(sel_in), .ready_out(ready_out),
    .valid_out(valid_out), .data_out(data_out), .rr_ptr(rr_ptr), .sel_err(sel_err));

  demux1an_rr_param #(.DATA_W(4), .N_CH(3), .HOLD(0)) u_dut3 (
    .clk_2f(clk_2f), .reset(reset), .valid_in(v3), .data_in(d3),
    .ready_in(rin3), .mode(m3), .sel_in(s3), .ready_out(r3),
    .valid_out(vout3), .data_out(dout3), .rr_ptr(ptr3), .sel_err(serr3));

  typedef struct {
    logic       vin;
    logic       mode;
    logic [1:0] sel;
    logic [3:0] rdy;
    logic [3:0] din;
    logic       rin;
    logic [3:0] vout;
    logic [1:0] ptr;
  } vec_t;

  typedef struct {
    logic [3:0]  vout;
    logic [15:0] dout;
    logic [1:0]  ptr;
  } exp_t;

  int checks = 0;
  int errors = 0;
  exp_t sbq[$];
  logic [3:0] edata[4];
  vec_t tbl[17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Entered shortly after a rising edge: drive, check ready_in, then check registered outputs.
  task automatic step(input vec_t v, input int idx);
    exp_t e;
    string nm;
    nm = $sformatf("row%0d", idx);
    valid_in = v.vin; mode = v.mode; sel_in = v.sel; ready_out = v.rdy; data_in = v.din;
    #1;
    chk({nm, " ready_in"}, 32'(ready_in), 32'(v.rin));
    for (int k = 0; k < 4; k++) if (v.vout[k]) edata[k] = v.din;
    e.vout = v.vout;
    e.dout = {edata[3], edata[2], edata[1], edata[0]};
    e.ptr  = v.ptr;
    sbq.push_back(e);
    @(posedge clk_2f); #1;
    if (sbq.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s scoreboard: got empty queue expected entry", nm);
    end else begin
      e = sbq.pop_front();
      chk({nm, " valid_out"}, 32'(valid_out), 32'(e.vout));
      chk({nm, " data_out"},  32'(data_out),  32'(e.dout));
      chk({nm, " rr_ptr"},    32'(rr_ptr),    32'(e.ptr));
      chk({nm, " sel_err"},   32'(sel_err),   32'(1'b0));
    end
  endtask

  initial begin
    //              vin mode sel rdy      din    rin  vout     ptr
    tbl[0]  = '{1'b1, 1'b0, 2'd0, 4'hF,    4'h1, 1'b1, 4'b0001, 2'd1};
    tbl[1]  = '{1'b1, 1'b0, 2'd0, 4'hF,    4'h2, 1'b1, 4'b0010, 2'd2};
    tbl[2]  = '{1'b1, 1'b0, 2'd0, 4'hF,    4'h3, 1'b1, 4'b0100, 2'd3};
    tbl[3]  = '{1'b1, 1'b0, 2'd0, 4'hF,    4'h4, 1'b1, 4'b1000, 2'd0};
    tbl[4]  = '{1'b1, 1'b0, 2'd0, 4'hF,    4'h5, 1'b1, 4'b0001, 2'd1};
    tbl[5]  = '{1'b1, 1'b0, 2'd0, 4'hF,    4'h6, 1'b1, 4'b0010, 2'd2};
    tbl[6]  = '{1'b1, 1'b0, 2'd0, 4'b1011, 4'hA, 1'b0, 4'b0000, 2'd2};
    tbl[7]  = '{1'b1, 1'b0, 2'd0, 4'b1011, 4'hA, 1'b0, 4'b0000, 2'd2};
    tbl[8]  = '{1'b1, 1'b0, 2'd0, 4'hF,    4'hA, 1'b1, 4'b0100, 2'd3};
    tbl[9]  = '{1'b0, 1'b0, 2'd0, 4'hF,    4'hD, 1'b1, 4'b0000, 2'd3};
    tbl[10] = '{1'b1, 1'b1, 2'd3, 4'hF,    4'h7, 1'b1, 4'b1000, 2'd3};
    tbl[11] = '{1'b1, 1'b1, 2'd1, 4'hF,    4'h8, 1'b1, 4'b0010, 2'd3};
    tbl[12] = '{1'b1, 1'b1, 2'd1, 4'hF,    4'h9, 1'b1, 4'b0010, 2'd3};
    tbl[13] = '{1'b1, 1'b0, 2'd1, 4'hF,    4'hB, 1'b1, 4'b1000, 2'd0};
    tbl[14] = '{1'b1, 1'b1, 2'd0, 4'b1110, 4'hC, 1'b0, 4'b0000, 2'd0};
    tbl[15] = '{1'b0, 1'b0, 2'd0, 4'b1110, 4'hC, 1'b0, 4'b0000, 2'd0};
    tbl[16] = '{1'b1, 1'b0, 2'd0, 4'b0001, 4'hE, 1'b1, 4'b0001, 2'd1};
    for (int k = 0; k < 4; k++) edata[k] = 4'h0;

    valid_in = 0; mode = 0; sel_in = 0; ready_out = 0; data_in = 0;
    v3 = 0; m3 = 0; s3 = 0; r3 = 0; d3 = 0;
    reset = 1'b1;
    #2;
    chk("reset valid_out", 32'(valid_out), 0);
    chk("reset data_out",  32'(data_out),  0);
    chk("reset rr_ptr",    32'(rr_ptr),    0);
    chk("reset sel_err",   32'(sel_err),   0);
    chk("reset ready_in",  32'(ready_in),  0);
    @(posedge clk_2f); #3;
    reset = 1'b0;
    @(posedge clk_2f); #1;

    for (int i = 0; i < 17; i++) step(tbl[i], i);
    valid_in = 0;

    // N_CH=3, HOLD=0
    v3 = 1; m3 = 0; r3 = 3'b111; d3 = 4'h5;
    #1 chk("n3 ready_in", 32'(rin3), 1);
    @(posedge clk_2f); #1;
    chk("n3 acc valid_out", 32'(vout3), 32'b001);
    chk("n3 acc data_out",  32'(dout3), 32'h005);
    chk("n3 acc rr_ptr",    32'(ptr3),  1);
    v3 = 0;
    @(posedge clk_2f); #1;
    chk("n3 idle valid_out", 32'(vout3), 0);
    chk("n3 idle data_out",  32'(dout3), 0);
    v3 = 1; m3 = 1; s3 = 2'd3; d3 = 4'h9;
    #1 chk("n3 oor ready_in", 32'(rin3), 0);
    @(posedge clk_2f); #1;
    chk("n3 oor sel_err",   32'(serr3), 1);
    chk("n3 oor valid_out", 32'(vout3), 0);
    chk("n3 oor data_out",  32'(dout3), 0);
    chk("n3 oor rr_ptr",    32'(ptr3),  1);
    v3 = 0;
    @(posedge clk_2f); #1;
    chk("n3 sel_err pulse end", 32'(serr3), 0);
    m3 = 0; v3 = 1; d3 = 4'h6;
    @(posedge clk_2f); #1;
    chk("n3 ch1 rr_ptr", 32'(ptr3), 2);
    d3 = 4'h7;
    @(posedge clk_2f); #1;
    chk("n3 wrap rr_ptr",    32'(ptr3),  0);
    chk("n3 wrap valid_out", 32'(vout3), 32'b100);
    chk("n3 wrap data_out",  32'(dout3), 32'h700);
    v3 = 0; m3 = 1; s3 = 2'd3;
    @(posedge clk_2f); #1;
    chk("n3 oor no valid sel_err", 32'(serr3), 0);
    m3 = 0;

    // Async reset after two accepts, asserted between edges
    reset = 1'b1; #2; reset = 1'b0;
    @(posedge clk_2f); #1;
    valid_in = 1; mode = 0; ready_out = 4'hF; data_in = 4'h1;
    @(posedge clk_2f); #1;
    data_in = 4'h2;
    @(posedge clk_2f); #1;
    chk("pre-reset valid_out", 32'(valid_out), 32'b0010);
    chk("pre-reset rr_ptr",    32'(rr_ptr),    2);
    #2 reset = 1'b1;
    #1;
    chk("mid reset valid_out", 32'(valid_out), 0);
    chk("mid reset data_out",  32'(data_out),  0);
    chk("mid reset rr_ptr",    32'(rr_ptr),    0);
    chk("mid reset ready_in",  32'(ready_in),  0);
    @(posedge clk_2f); #3;
    chk("reset held valid_out", 32'(valid_out), 0);
    reset = 1'b0;
    data_in = 4'hE;
    @(posedge clk_2f); #1;
    chk("post-reset valid_out", 32'(valid_out), 32'b0001);
    chk("post-reset data_out",  32'(data_out),  32'h000E);
    chk("post-reset rr_ptr",    32'(rr_ptr),    1);
    valid_in = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
